ddr_rd_burst_ctrl: RTL and testbench
====================================

# ddr_rd_burst_ctrl

Read-side DDR burst scheduler feeding the 256-bit write port of the read_ddr_fifo (1024 x 256 write side, 32-bit read side). It walks one frame buffer in DDR, issuing AXI4 read bursts only when the FIFO has room for a whole burst. Returned beats are written straight into the FIFO. It runs entirely in the FIFO write-clock (DDR user clock) domain.

## Interface
- ADDR_WIDTH, 28: AXI byte-address width.
- DATA_WIDTH, 256: AXI/FIFO data width; BYTES_PER_BEAT = DATA_WIDTH/8 = 32.
- BURST_LEN, 16: beats per full burst (1..256).
- FRAME_BASE, 28'h000_0000: byte address of frame start; must be aligned to BURST_LEN*BYTES_PER_BEAT.
- FRAME_BEATS, 259200: beats per frame (1..2^20-1).
- FIFO_DEPTH, 1024: FIFO write-side depth in beats.
- CONTINUOUS, 1: 1 = restart at FRAME_BASE after the frame ends; 0 = return to IDLE.
- wr_clk  in  1  single clock.
- wr_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame at FRAME_BASE.
- fifo_water_level  in  11  FIFO wr_water_level.
- fifo_full  in  1  FIFO wr_full.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- axi_araddr  out  ADDR_WIDTH  burst byte address.
- axi_arlen  out  8  beats - 1.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address accept.
- axi_rdata  in  DATA_WIDTH  read data.
- axi_rvalid  in  1  read beat valid.
- axi_rlast  in  1  last beat of the burst.
- axi_rready  out  1  read beat accept.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last beat of a frame.
- proto_err  out  1  sticky; set when a beat arrives with rvalid outside DATA or with rlast at the wrong count.

## Operation
- States: IDLE, WAIT_SPACE, ADDR, DATA, SETTLE, DONE.
- IDLE: on start, load beat_idx=0 and remaining=FRAME_BEATS, then go to WAIT_SPACE.
- WAIT_SPACE: move to ADDR when fifo_water_level <= FIFO_DEPTH - BURST_LEN; otherwise hold.
- ADDR: arvalid=1.
  - axi_araddr = FRAME_BASE + beat_idx*BYTES_PER_BEAT, truncated to ADDR_WIDTH.
  - axi_arlen = min(BURST_LEN, remaining) - 1.
  - Address and length are registered and stay stable until arready.
  - On arvalid&arready, go to DATA and load beat_cnt = arlen+1.
- DATA: axi_rready = ~fifo_full.
  - fifo_wr_en = axi_rvalid & axi_rready.
  - fifo_wr_data = axi_rdata, combinational pass-through.
  - Each accepted beat decrements beat_cnt and remaining and increments beat_idx.
  - The accepted beat with beat_cnt==1 ends the burst and goes to SETTLE. proto_err is set if rlast does not coincide with that beat.
- SETTLE: hold 2 cycles so the FIFO water level reflects the writes. Then:
  - restart_pend set: beat_idx=0, remaining=FRAME_BEATS, clear restart_pend, go to WAIT_SPACE.
  - remaining==0: go to DONE.
  - otherwise: go to WAIT_SPACE.
- DONE: pulse frame_done for 1 cycle. Then, if CONTINUOUS, reload and go to WAIT_SPACE; otherwise go to IDLE.
- Only one burst is outstanding at a time. No burst is issued unless it fits in the FIFO, so the FIFO never overflows.
- start while busy sets restart_pend. The current burst always completes; the restart takes effect at SETTLE exit (or DONE exit, which reloads anyway). Never abort mid-burst.
- axi_rvalid outside DATA: set proto_err, keep rready=0, do not write.
- Final burst shorter than BURST_LEN when FRAME_BEATS mod BURST_LEN != 0.

## Timing
- Reset values: state=IDLE; arvalid, rready, fifo_wr_en, busy, frame_done, proto_err = 0; araddr=0; arlen=0. All take effect immediately on wr_rst assertion, including mid-burst. In-flight AXI data after reset is the system's responsibility.
- start at cycle 0 → WAIT_SPACE at cycle 1 → arvalid at cycle 2 if space is available.
- Beat-to-FIFO latency is 0 cycles (same-cycle write).
- After a burst's last beat: 2 SETTLE cycles, then 1 cycle in WAIT_SPACE. The earliest next arvalid is 4 cycles after the last beat.
- frame_done is high in the cycle after SETTLE exits with remaining==0.

## Structure
- Package ddr_rd_burst_ctrl_pkg holds:
  - the state enum;
  - BYTES_PER_BEAT;
  - the SETTLE_CYCLES=2 constant;
  - the min() length function.
- No sub-module is natural: a single FSM plus counters, about 200 lines.

## Test plan
- FRAME_BEATS=64, BURST_LEN=16, level=0, arready=1, rvalid always 1 → 4 bursts with araddr 0x0, 0x200, 0x400, 0x600 and arlen=15; 64 fifo writes; one frame_done; busy falls (CONTINUOUS=0).
- FRAME_BEATS=40 → arlen sequence 15, 15, 7; last araddr 0x400; 40 writes.
- fifo_water_level=1009 held → no arvalid. Drop it to 1008 → arvalid 1 cycle later.
- fifo_full asserted for 5 cycles mid-burst → rready low for those 5 cycles; no beats lost; beat count and rlast still aligned.
- start pulsed during DATA of burst 2 → burst 2 completes; the next araddr = FRAME_BASE.
- rvalid in IDLE → proto_err=1 and no fifo_wr_en. Assert wr_rst mid-DATA → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/ddr_rd_burst_ctrl_pkg.sv
// Shared types and constants for the DDR read-side burst scheduler.
// The beat size is fixed by the 256-bit FIFO write port.
package ddr_rd_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StAddr,
    StData,
    StSettle,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_BEAT = 32;

  // Cycles spent after a burst so the FIFO water level catches up with the writes.
  localparam int unsigned SETTLE_CYCLES = 2;

  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_rd_burst_ctrl.sv
// Walks one DDR frame buffer with single-outstanding AXI4 read bursts and writes
// the returned beats straight into the read FIFO, only when a whole burst fits.
module ddr_rd_burst_ctrl
  import ddr_rd_burst_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter int unsigned           DATA_WIDTH  = 256,
  parameter int unsigned           BURST_LEN   = 16,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = '0,
  parameter int unsigned           FRAME_BEATS = 259200,
  parameter int unsigned           FIFO_DEPTH  = 1024,
  parameter bit                    CONTINUOUS  = 1'b1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  start,
  input  logic [10:0]           fifo_water_level,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rvalid,
  input  logic                  axi_rlast,
  output logic                  axi_rready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  proto_err
);

  localparam logic [19:0] FrameBeats = 20'(FRAME_BEATS);
  localparam logic [10:0] SpaceLevel = 11'(FIFO_DEPTH - BURST_LEN);
  localparam int unsigned BeatShift  = $clog2(BYTES_PER_BEAT);

  state_e                  state_q;
  logic [19:0]             beat_idx_q;
  logic [19:0]             remaining_q;
  logic [8:0]              beat_cnt_q;
  logic [1:0]              settle_q;
  logic                    restart_q;
  logic                    arvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic                    proto_err_q;

  logic [31:0]             byte_off;
  logic [ADDR_WIDTH-1:0]   araddr_next;
  logic [7:0]              arlen_next;
  logic                    rready;
  logic                    beat_acc;
  logic                    last_beat;

  assign byte_off    = {12'd0, beat_idx_q} << BeatShift;
  assign araddr_next = FRAME_BASE + byte_off[ADDR_WIDTH-1:0];
  assign arlen_next  = 8'(min_len(BURST_LEN, 32'(remaining_q)) - 32'd1);

  assign rready    = (state_q == StData) && !fifo_full;
  assign beat_acc  = rready && axi_rvalid;
  assign last_beat = (beat_cnt_q == 9'd1);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q     <= StIdle;
      beat_idx_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      settle_q    <= '0;
      restart_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (axi_rvalid && (state_q != StData)) proto_err_q <= 1'b1;
      // A restart request is parked until the current burst has fully drained.
      if (start && (state_q != StIdle)) restart_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            beat_idx_q  <= '0;
            remaining_q <= FrameBeats;
            state_q     <= StWaitSpace;
          end
        end
        StWaitSpace: begin
          if (fifo_water_level <= SpaceLevel) begin
            arvalid_q <= 1'b1;
            araddr_q  <= araddr_next;
            arlen_q   <= arlen_next;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (axi_arready) begin
            arvalid_q  <= 1'b0;
            beat_cnt_q <= {1'b0, arlen_q} + 9'd1;
            state_q    <= StData;
          end
        end
        StData: begin
          if (beat_acc) begin
            beat_cnt_q  <= beat_cnt_q - 9'd1;
            remaining_q <= remaining_q - 20'd1;
            beat_idx_q  <= beat_idx_q + 20'd1;
            if (last_beat != axi_rlast) proto_err_q <= 1'b1;
            if (last_beat) begin
              settle_q <= 2'(SETTLE_CYCLES - 1);
              state_q  <= StSettle;
            end
          end
        end
        StSettle: begin
          if (settle_q != 2'd0) begin
            settle_q <= settle_q - 2'd1;
          end else if (restart_q || start) begin
            beat_idx_q  <= '0;
            remaining_q <= FrameBeats;
            restart_q   <= 1'b0;
            state_q     <= StWaitSpace;
          end else if (remaining_q == 20'd0) begin
            state_q <= StDone;
          end else begin
            state_q <= StWaitSpace;
          end
        end
        StDone: begin
          if (CONTINUOUS || restart_q || start) begin
            beat_idx_q  <= '0;
            remaining_q <= FrameBeats;
            restart_q   <= 1'b0;
            state_q     <= StWaitSpace;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign axi_arvalid  = arvalid_q;
  assign axi_araddr   = araddr_q;
  assign axi_arlen    = arlen_q;
  assign axi_rready   = rready;
  assign fifo_wr_en   = beat_acc;
  assign fifo_wr_data = axi_rdata;
  assign busy         = (state_q != StIdle);
  assign frame_done   = (state_q == StDone);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Self-checking bench: a randomized AXI read slave checked against a burst-list
// model derived from the frame geometry, plus directed corner cases.
module tb_ddr_rd_burst_ctrl;

  localparam int unsigned     AW    = 28;
  localparam int unsigned     DW    = 256;
  localparam int unsigned     BL    = 16;
  localparam int unsigned     FB    = 40;
  localparam int unsigned     DEPTH = 1024;
  localparam logic [AW-1:0]   BASE  = 28'h000_1000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          start;
  logic [10:0]   fifo_water_level;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid;
  logic          axi_rlast;
  logic          axi_rready;
  logic          busy;
  logic          frame_done;
  logic          proto_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc_n = 0;

  burst_t      exp_q[$];
  int unsigned start_cyc, last_beat_cyc, gidx, nwr, left, w, k, dly;
  logic        vld, full, hold;

  ddr_rd_burst_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .FRAME_BASE (BASE),
    .FRAME_BEATS(FB),
    .FIFO_DEPTH (DEPTH),
    .CONTINUOUS (1'b0)
  ) dut (
    .wr_clk          (wr_clk),
    .wr_rst          (wr_rst),
    .start           (start),
    .fifo_water_level(fifo_water_level),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .axi_araddr      (axi_araddr),
    .axi_arlen       (axi_arlen),
    .axi_arvalid     (axi_arvalid),
    .axi_arready     (axi_arready),
    .axi_rdata       (axi_rdata),
    .axi_rvalid      (axi_rvalid),
    .axi_rlast       (axi_rlast),
    .axi_rready      (axi_rready),
    .busy            (busy),
    .frame_done      (frame_done),
    .proto_err       (proto_err)
  );

  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc_n <= cyc_n + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wr_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_data(input int unsigned n);
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = n * 32'h9E37_79B9 + 32'(i);
    return d;
  endfunction

  initial begin
    wr_rst = 1'b1; start = 1'b0; fifo_water_level = '0; fifo_full = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    gidx = 0; nwr = 0; last_beat_cyc = 0;

    // Expected burst list: two bursts of an interrupted frame, then one whole frame.
    for (int unsigned b = 0; b < 2; b++)
      exp_q.push_back(burst_t'{addr: AW'(BASE + b * BL * 32), len: 8'(BL - 1)});
    for (int unsigned n = 0; n < FB; n += BL)
      exp_q.push_back(burst_t'{addr: AW'(BASE + n * 32),
                               len: 8'((((FB - n) < BL) ? (FB - n) : BL) - 1)});

    cyc(); cyc();
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen", axi_arlen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    wr_rst = 1'b0;
    cyc();

    // Frame run with random arready delay, rvalid gaps and fifo_full back-pressure.
    start = 1'b1; start_cyc = cyc_n;
    cyc();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int b = 0; b < exp_q.size(); b++) begin
      w = 0;
      while (axi_arvalid !== 1'b1 && w < 60) begin
        chk("rready_outside_data", axi_rready, 0);
        chk("no_frame_done_mid", frame_done, 0);
        cyc();
        w++;
      end
      chk("ar_timeout", (w < 60), 1);
      if (b == 0) chk("first_ar_latency", cyc_n - start_cyc, 2);
      else        chk("ar_gap_after_last_beat", cyc_n - last_beat_cyc, 4);

      dly = $urandom_range(0, 3);
      for (int unsigned d = 0; d <= dly; d++) begin
        axi_arready = (d == dly);
        chk("ar_valid_hold", axi_arvalid, 1);
        chk("ar_addr", axi_araddr, exp_q[b].addr);
        chk("ar_len", axi_arlen, exp_q[b].len);
        cyc();
      end
      axi_arready = 1'b0;
      chk("ar_valid_drop", axi_arvalid, 0);

      left = exp_q[b].len + 1; hold = 1'b0; k = 0;
      while (left > 0 && k < 300) begin
        vld  = hold ? 1'b1 : ($urandom_range(0, 9) < 7);
        full = (b == 0 && k >= 3 && k < 8) ? 1'b1 : ($urandom_range(0, 9) == 0);
        axi_rvalid = vld; fifo_full = full;
        axi_rlast  = vld && (left == 1);
        axi_rdata  = beat_data(gidx);
        start      = (b == 1 && k == 0);
        #2;
        chk("rready_vs_full", axi_rready, !full);
        chk("wr_en", fifo_wr_en, vld && !full);
        if (vld && !full) begin
          chk("wr_data", fifo_wr_data, beat_data(gidx));
          left--; gidx++; nwr++;
          if (left == 0) last_beat_cyc = cyc_n;
        end
        hold = vld && full;
        k++;
        cyc();
      end
      chk("data_timeout", (left == 0), 1);
      axi_rvalid = 1'b0; axi_rlast = 1'b0; fifo_full = 1'b0; start = 1'b0;
    end

    chk("frame_done_settle1", frame_done, 0);
    chk("busy_settle1", busy, 1);
    cyc();
    chk("frame_done_settle2", frame_done, 0);
    cyc();
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_in_done", busy, 1);
    cyc();
    chk("frame_done_clear", frame_done, 0);
    chk("busy_falls", busy, 0);
    chk("total_writes", nwr, 72);
    chk("proto_err_clean", proto_err, 0);

    // Water level one beat above the burst threshold blocks issue.
    fifo_water_level = 11'(DEPTH - BL + 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("no_ar_when_full", axi_arvalid, 0);
      cyc();
    end
    fifo_water_level = 11'(DEPTH - BL);
    #2;
    chk("ar_not_yet", axi_arvalid, 0);
    cyc();
    chk("ar_after_space", axi_arvalid, 1);
    chk("ar_addr_space", axi_araddr, BASE);
    chk("ar_len_space", axi_arlen, BL - 1);

    // Asynchronous reset in the middle of a data phase.
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = beat_data(7);
    #2;
    chk("wr_en_pre_reset", fifo_wr_en, 1);
    cyc();
    wr_rst = 1'b1;
    #1;
    chk("rstmid_arvalid", axi_arvalid, 0);
    chk("rstmid_rready", axi_rready, 0);
    chk("rstmid_wr_en", fifo_wr_en, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_frame_done", frame_done, 0);
    chk("rstmid_proto_err", proto_err, 0);
    chk("rstmid_araddr", axi_araddr, 0);
    chk("rstmid_arlen", axi_arlen, 0);
    axi_rvalid = 1'b0;
    cyc();
    wr_rst = 1'b0;
    fifo_water_level = '0;
    cyc();

    // Stray rvalid while idle.
    axi_rvalid = 1'b1;
    #2;
    chk("idle_rvalid_wr_en", fifo_wr_en, 0);
    chk("idle_rvalid_rready", axi_rready, 0);
    chk("idle_proto_err_pre", proto_err, 0);
    cyc();
    axi_rvalid = 1'b0;
    chk("idle_proto_err_set", proto_err, 1);
    cyc();
    chk("proto_err_sticky", proto_err, 1);
    wr_rst = 1'b1;
    #2;
    chk("proto_err_reset", proto_err, 0);
    cyc();
    wr_rst = 1'b0;
    cyc();

    // rlast on the first beat of a 16-beat burst.
    start = 1'b1;
    cyc();
    start = 1'b0;
    w = 0;
    while (axi_arvalid !== 1'b1 && w < 20) begin
      cyc();
      w++;
    end
    chk("ar_timeout_rlast", (w < 20), 1);
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rdata = beat_data(3);
    #2;
    chk("early_rlast_wr_en", fifo_wr_en, 1);
    chk("early_rlast_pre", proto_err, 0);
    cyc();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    chk("early_rlast_err", proto_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
